// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
//
// Two-source arbiter that drives the select of a downstream 2:1 mux. A grant
// lasts up to HOLD cycles (a "tenure"). The owner can release early by
// dropping its request. At the end of a tenure the grant passes straight to
// the other source if it is requesting, with no idle cycle in between.
// Simultaneous requests from IDLE go to the source that was not granted
// most recently.
//
// Parameters
//   HOLD       tenure length in clock cycles, legal range 1..15
//
// Ports
//   clk_in     clock; all state changes on its rising edge
//   rst_in     synchronous, active-high reset
//   req_a_in   request from source A (mux input a side)
//   req_b_in   request from source B (mux input b side)
//   sel_out    registered mux select: 0 = A, 1 = B; holds its value in IDLE
//   gnt_a_out  registered grant to source A
//   gnt_b_out  registered grant to source B
//   busy_out   registered, high while either grant is active
//   cnt_out    cycles elapsed in the current tenure, 0-based; 0 in IDLE
// ---------------------------------------------------------------------------
module mux_sel_arbiter #(
   parameter int unsigned HOLD = 4
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       req_a_in,
   input  logic       req_b_in,
   output logic       sel_out,
   output logic       gnt_a_out,
   output logic       gnt_b_out,
   output logic       busy_out,
   output logic [3:0] cnt_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(HOLD - 1);

   state_t     state, state_nxt;
   logic       last_b, last_b_nxt;   // most recent winner was B
   logic [3:0] cnt_nxt;
   logic       sel_nxt;

   // Next-state logic. Tenure end and early release resolve the same way:
   // the other source wins if it is requesting; otherwise the owner is
   // re-granted if it is still requesting, else the arbiter goes idle.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_nxt  = state;
      last_b_nxt = last_b;
      cnt_nxt    = 4'd0;

      unique case (state)
         IDLE: begin
            if (req_a_in && (!req_b_in || last_b)) begin
               state_nxt  = GNT_A;
               last_b_nxt = 1'b0;
            end else if (req_b_in) begin
               state_nxt  = GNT_B;
               last_b_nxt = 1'b1;
            end
         end

         GNT_A: begin
            if (!req_a_in || cnt_out == CNT_MAX) begin
               if (req_b_in) begin
                  state_nxt  = GNT_B;
                  last_b_nxt = 1'b1;
               end else if (req_a_in) begin
                  state_nxt  = GNT_A;   // re-grant, counter restarts
               end else begin
                  state_nxt  = IDLE;
               end
            end else begin
               cnt_nxt = cnt_out + 4'd1;
            end
         end

         GNT_B: begin
            if (!req_b_in || cnt_out == CNT_MAX) begin
               if (req_a_in) begin
                  state_nxt  = GNT_A;
                  last_b_nxt = 1'b0;
               end else if (req_b_in) begin
                  state_nxt  = GNT_B;   // re-grant, counter restarts
               end else begin
                  state_nxt  = IDLE;
               end
            end else begin
               cnt_nxt = cnt_out + 4'd1;
            end
         end

         default: state_nxt = IDLE;
      endcase

      // Select follows the next owner and holds its value through IDLE.
      sel_nxt = sel_out;
      if (state_nxt == GNT_A) sel_nxt = 1'b0;
      if (state_nxt == GNT_B) sel_nxt = 1'b1;
   end

   // All outputs come straight from flops loaded with next-cycle values, so a
   // request sampled at one edge shows up as a grant right after that edge.
   always_ff @(posedge clk_in) begin
      // NOTE: state is updated with non-blocking assignments so that every
      // flop samples the pre-edge values, regardless of statement order.
      if (rst_in) begin
         state     <= IDLE;
         last_b    <= 1'b1;   // A wins the first tie after reset
         sel_out   <= 1'b0;
         gnt_a_out <= 1'b0;
         gnt_b_out <= 1'b0;
         busy_out  <= 1'b0;
         cnt_out   <= 4'd0;
      end else begin
         state     <= state_nxt;
         last_b    <= last_b_nxt;
         sel_out   <= sel_nxt;
         gnt_a_out <= (state_nxt == GNT_A);
         gnt_b_out <= (state_nxt == GNT_B);
         busy_out  <= (state_nxt != IDLE);
         cnt_out   <= cnt_nxt;
      end
   end

endmodule
